ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Receives PS/2 keyboard frames on ps2Clck/ps2Data and turns scan codes for the four game keys into
//  a one-cycle hit strobe plus a 2-bit key index.
//  Sits directly upstream of the hit/score logic: ifPressed feeds timeCount, keyPressed feeds ifScore,
//  where it is compared against the 2-bit mole index.
//  Suppresses typematic auto-repeat, so one physical press yields exactly one hit.
// PARAMETERS
//  FILTER_LEN   8        consecutive equal samples needed before the filtered PS/2 clock changes level
//  TIMEOUT_CYC  100000   systemClock cycles (2 ms @ 50 MHz) allowed between edges inside a frame
//  KEY0_CODE    8'h1D    make code mapped to index 0 (W)
//  KEY1_CODE    8'h1C    make code mapped to index 1 (A)
//  KEY2_CODE    8'h1B    make code mapped to index 2 (S)
//  KEY3_CODE    8'h23    make code mapped to index 3 (D)
// PORTS
//  systemClock  in   1  50 MHz system clock; the only clock
//  reset        in   1  asynchronous, active-low reset
//  ps2Clck      in   1  raw PS/2 clock from the keyboard; asynchronous to systemClock
//  ps2Data      in   1  raw PS/2 data from the keyboard; asynchronous to systemClock
//  ifPressed    out  1  one-cycle pulse on a fresh make of a mapped key
//  keyPressed   out  2  index of the last fresh mapped key; held until the next one
//  rxByte       out  8  last correctly framed byte
//  rxValid      out  1  one-cycle pulse when rxByte updates
//  frameErr     out  1  one-cycle pulse on a start, parity, stop or timeout error
// BEHAVIOUR
//  Clocking and reset
//   - Single clock domain, systemClock.
//   - While reset=0, every output is 0: ifPressed, keyPressed=2'b00, rxByte=8'h00, rxValid, frameErr.
//   - Reset also clears the FSM, the flags and the synchronisers.
//   - Reset mid-frame discards the partial frame; reception restarts at the next start bit.
//  Input conditioning
//   - ps2Clck and ps2Data each pass through a 2-flop synchroniser.
//   - The synchronised clock then goes through a FILTER_LEN glitch filter.
//   - A falling edge of the filtered clock gives a one-cycle fall strobe; ps2Data is sampled on it.
//  Frame FSM (advances on fall strobes only)
//   - IDLE: data=0 -> DATA; data=1 -> frameErr pulse, stay in IDLE.
//   - DATA: shift in 8 bits, LSB first.
//   - PAR: odd parity across the 8 data bits plus the parity bit.
//   - STOP: data must be 1.
//   - The cycle after the STOP fall strobe: if parity and stop are good, rxValid=1 and rxByte updates.
//     Otherwise frameErr=1 and rxByte is unchanged. Either way the FSM returns to IDLE.
//   - Watchdog counter is cleared on every fall strobe. Reaching TIMEOUT_CYC while not in IDLE gives
//     frameErr and a return to IDLE.
//  Scan-code decode (acts on rxValid only)
//   - 8'hF0 sets brk; 8'hE0 sets ext. Neither byte produces a hit.
//   - Any other byte with ext=1 is ignored; brk and ext both clear.
//   - Byte with brk=1 and matching KEYn_CODE: clear held[n]; brk clears.
//   - Byte with brk=0, matching KEYn_CODE, held[n]=0: set held[n], keyPressed=n, ifPressed=1.
//     The pulse shares the cycle after rxValid.
//   - Same byte with held[n]=1 is a typematic repeat: no pulse, no change.
//   - Unmapped codes: no effect on outputs; they clear brk and ext.
//   - Latency from the STOP fall strobe: rxValid +1 cycle, ifPressed +2 cycles.
//  Boundaries
//   - Two different mapped keys held: each one's first make pulses; keyPressed follows the latest.
//   - A frame error between F0 and its code leaves brk set; the next good byte consumes it.
//   - The filter absorbs ps2Clck glitches shorter than FILTER_LEN cycles; no strobe is produced.
// STRUCTURE
//  - Shared package ps2_pkg: F0/E0 prefix constants, default key codes, frame state encoding.
//  - Sub-module ps2_rx_frame: synchronisers, filter, edge detect, frame FSM and watchdog.
//    Outputs rxByte, rxValid and frameErr.
//  - Top level holds the brk/ext/held[3:0] decode registers and the output registers.
// TESTING
//  - Frame 0x1D with good parity -> rxValid with rxByte=8'h1D, then ifPressed with keyPressed=2'd0.
//  - Sequence 1C,1C,1C,F0,1C,1C -> ifPressed exactly twice, at the first and last 1C; keyPressed=1.
//  - Frame 0x23 with wrong parity bit -> frameErr once; no rxValid, no ifPressed; keyPressed unchanged.
//  - E0,1D then 0x44 -> no ifPressed; ext cleared (a following 1B pulses with keyPressed=2).
//  - Stop clocking after 4 data bits, wait TIMEOUT_CYC -> frameErr; a following good 0x1B frame pulses.
//  - Assert reset mid-frame, plus 3-cycle clock glitches -> all outputs 0, no fall strobe, next frame decodes.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code prefixes, default key codes and frame state encoding
package ps2_pkg;
    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;
    localparam logic [7:0] KEY0_DEF = 8'h1D;
    localparam logic [7:0] KEY1_DEF = 8'h1C;
    localparam logic [7:0] KEY2_DEF = 8'h1B;
    localparam logic [7:0] KEY3_DEF = 8'h23;
    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} frame_state_t;
endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: PS/2 line inputs and decoded key/byte outputs
interface ps2_key_decoder_if;
    logic       ps2Clck;
    logic       ps2Data;
    logic       ifPressed;
    logic [1:0] keyPressed;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       frameErr;
    modport master (output ps2Clck, ps2Data, input ifPressed, keyPressed, rxByte, rxValid, frameErr);
    modport slave (input ps2Clck, ps2Data, output ifPressed, keyPressed, rxByte, rxValid, frameErr);
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronise and filter the PS/2 lines, then deframe 11-bit frames with a watchdog
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       systemClock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [1:0]    clk_sync, data_sync;
    logic          filt, filt_d, fall, good;
    logic [FW-1:0] flt_cnt;
    logic [WW-1:0] wd;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    frame_state_t  state;
    assign fall = filt_d & ~filt;
    assign good = (^{shift, par}) & data_sync[1];
    always_ff @(posedge systemClock or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '0;
            data_sync <= '0;
            filt      <= 1'b1;
            filt_d    <= 1'b1;
            flt_cnt   <= '0;
            wd        <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par       <= 1'b0;
            state     <= IDLE;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt_d    <= filt;
            // the filtered clock only moves after FILTER_LEN consecutive disagreeing samples
            if (clk_sync[1] == filt) flt_cnt <= '0;
            else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt    <= clk_sync[1];
                flt_cnt <= '0;
            end else flt_cnt <= flt_cnt + 1'b1;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            wd        <= (fall || state == IDLE) ? '0 : wd + 1'b1;
            if (fall) begin
                case (state)
                    IDLE: begin
                        state     <= data_sync[1] ? IDLE : DATA;
                        frame_err <= data_sync[1];
                        bit_cnt   <= '0;
                    end
                    DATA: begin
                        shift   <= {data_sync[1], shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= (bit_cnt == 3'd7) ? PAR : DATA;
                    end
                    PAR: begin
                        par   <= data_sync[1];
                        state <= STOP;
                    end
                    STOP: begin
                        rx_valid  <= good;
                        frame_err <= ~good;
                        rx_byte   <= good ? shift : rx_byte;
                        state     <= IDLE;
                    end
                endcase
            end else if (state != IDLE && wd == WW'(TIMEOUT_CYC - 1)) begin
                frame_err <= 1'b1;
                state     <= IDLE;
            end
        end
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turn PS/2 make/break codes of four game keys into one hit pulse per physical press
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int         FILTER_LEN  = 8,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] KEY0_CODE   = KEY0_DEF,
    parameter logic [7:0] KEY1_CODE   = KEY1_DEF,
    parameter logic [7:0] KEY2_CODE   = KEY2_DEF,
    parameter logic [7:0] KEY3_CODE   = KEY3_DEF
) (
    input logic              systemClock,
    input logic              reset,
    ps2_key_decoder_if.slave bus
);
    logic       brk, ext, ifp;
    logic [3:0] held, hit;
    logic [1:0] idx, kp;
    ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .systemClock(systemClock),
        .reset      (reset),
        .ps2_clk    (bus.ps2Clck),
        .ps2_data   (bus.ps2Data),
        .rx_byte    (bus.rxByte),
        .rx_valid   (bus.rxValid),
        .frame_err  (bus.frameErr)
    );
    always_comb begin
        hit = {bus.rxByte == KEY3_CODE, bus.rxByte == KEY2_CODE, bus.rxByte == KEY1_CODE, bus.rxByte == KEY0_CODE};
        idx = hit[3] ? 2'd3 : hit[2] ? 2'd2 : hit[1] ? 2'd1 : 2'd0;
    end
    always_ff @(posedge systemClock or negedge reset) begin
        if (!reset) begin
            brk  <= 1'b0;
            ext  <= 1'b0;
            held <= '0;
            ifp  <= 1'b0;
            kp   <= '0;
        end else begin
            ifp <= 1'b0;
            if (bus.rxValid) begin
                if (bus.rxByte == BRK_CODE) brk <= 1'b1;
                else if (bus.rxByte == EXT_CODE) ext <= 1'b1;
                else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    // held suppresses typematic repeats until the matching break code
                    if (!ext && |hit) begin
                        if (brk) held[idx] <= 1'b0;
                        else if (!held[idx]) begin
                            held[idx] <= 1'b1;
                            kp        <= idx;
                            ifp       <= 1'b1;
                        end
                    end
                end
            end
        end
    end
    assign bus.ifPressed  = ifp;
    assign bus.keyPressed = kp;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: random and directed PS/2 frames scored against a queue-based key model
module tb_ps2_key_decoder;
    localparam int TO = 1000;
    localparam int H  = 20;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    ps2_key_decoder_if bus();
    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .systemClock(clk),
        .reset      (reset_n),
        .bus        (bus)
    );
    always #5 clk = ~clk;

    logic [7:0] codes [4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
    logic [7:0] pool [8]  = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hF0, 8'hE0, 8'h44, 8'h5A};
    bit         m_brk, m_ext;
    bit   [3:0] m_held;
    int         m_kp;
    logic [7:0] m_byte;
    logic [7:0] exp_rx [$];
    int         exp_key [$];
    int         exp_err;
    int         checks, failures;
    int         cyc, last_rx;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int lookup(logic [7:0] b);
        foreach (codes[i]) if (codes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_held = '0; m_kp = 0; m_byte = 8'h00;
    endtask

    task automatic model(logic [7:0] b);
        int k;
        k = lookup(b);
        exp_rx.push_back(b);
        m_byte = b;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (!m_ext && k >= 0) begin
                if (m_brk) m_held[k] = 0;
                else if (!m_held[k]) begin
                    m_held[k] = 1;
                    m_kp = k;
                    exp_key.push_back(k);
                end
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    // kind: 0 good frame, 1 bad parity, 2 bad stop; nbits < 11 abandons the frame
    task automatic send(logic [7:0] b, int kind, int nbits = 11);
        logic [10:0] f;
        f = {kind != 2, (~^b) ^ (kind == 1), b, 1'b0};
        if (nbits == 11) begin
            if (kind == 0) model(b);
            else exp_err++;
        end
        for (int i = 0; i < nbits; i++) begin
            bus.ps2Data = f[i];
            wait_cyc(H);
            bus.ps2Clck = 1'b0;
            wait_cyc(H);
            bus.ps2Clck = 1'b1;
        end
        bus.ps2Data = 1'b1;
        wait_cyc(2 * H);
        if (nbits == 11) begin
            check("keyPressed_held", bus.keyPressed, m_kp);
            check("rxByte_held", bus.rxByte, m_byte);
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, "_ifPressed"}, bus.ifPressed, 0);
        check({tag, "_keyPressed"}, bus.keyPressed, 0);
        check({tag, "_rxByte"}, bus.rxByte, 0);
        check({tag, "_rxValid"}, bus.rxValid, 0);
        check({tag, "_frameErr"}, bus.frameErr, 0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (bus.rxValid) begin
            last_rx = cyc;
            check("rxValid_expected", int'(exp_rx.size() > 0), 1);
            if (exp_rx.size() > 0) check("rxByte", bus.rxByte, exp_rx.pop_front());
        end
        if (bus.frameErr) begin
            check("frameErr_expected", int'(exp_err > 0), 1);
            if (exp_err > 0) exp_err--;
        end
        if (bus.ifPressed) begin
            check("ifPressed_expected", int'(exp_key.size() > 0), 1);
            if (exp_key.size() > 0) check("keyPressed", bus.keyPressed, exp_key.pop_front());
            check("ifPressed_latency", cyc - last_rx, 1);
        end
    end

    initial begin
        logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        last_rx = -10;
        bus.ps2Clck = 1'b1;
        bus.ps2Data = 1'b1;
        model_reset();
        wait_cyc(3);
        check_zero("reset");
        reset_n = 1'b1;
        wait_cyc(10);
        send(8'h1D, 0);
        foreach (seq[i]) send(seq[i], 0);
        send(8'h23, 1);
        send(8'hE0, 0);
        send(8'h1D, 0);
        send(8'h44, 0);
        send(8'h1B, 0);
        send(8'hF0, 0);
        send(8'h1B, 0);
        exp_err++;
        send(8'h00, 0, 5);
        wait_cyc(TO + 50);
        send(8'h1B, 0);
        send(8'hF0, 0);
        send(8'h1D, 2);
        send(8'h1D, 0);
        send(8'h1D, 0);
        send(8'hAA, 0, 4);
        reset_n = 1'b0;
        wait_cyc(3);
        check_zero("midreset");
        reset_n = 1'b1;
        model_reset();
        wait_cyc(10);
        repeat (5) begin
            bus.ps2Clck = 1'b0;
            wait_cyc(3);
            bus.ps2Clck = 1'b1;
            wait_cyc(10);
        end
        send(8'h1D, 0);
        repeat (40) begin
            int kind;
            kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            send(pool[$urandom_range(0, 7)], kind);
        end
        wait_cyc(50);
        check("rx_queue_drained", exp_rx.size(), 0);
        check("key_queue_drained", exp_key.size(), 0);
        check("err_pending_drained", exp_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
